// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like bridge: FSM states, access sizes
// and the kseg0/kseg1 fixed-mapping window.
package sram_like_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } bridge_state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;
   localparam logic [31:0] KSEG01_LO = 32'h8000_0000;
   localparam logic [31:0] KSEG01_HI = 32'hBFFF_FFFF;

   // kseg0/kseg1 are unmapped windows onto the low 512 MiB of physical memory
   function automatic logic [31:0] kseg_map(input logic [31:0] addr);
      if ((addr >= KSEG01_LO) && (addr <= KSEG01_HI)) begin
         return addr & KSEG_MASK;
      end
      return addr;
   endfunction

endpackage

// File: rtl/sram_like_bridge_rr_arbiter.sv
// Channel arbiter for the sram-like bridge: MODE 0 grants the highest requesting
// index, MODE 1 searches round-robin starting just after ptr.
module rr_arbiter
   import sram_like_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int MODE  = 0,
   parameter int PTR_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0]   req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NCH-1:0]   grant
);

   generate
      if (MODE == 0) begin : g_fixed
         logic unused_ptr;
         assign unused_ptr = ^ptr;

         always_comb begin
            grant = '0;
            for (int i = 0; i < NCH; i++) begin
               if (req[i]) begin
                  grant    = '0;
                  grant[i] = 1'b1;
               end
            end
         end
      end else begin : g_rr
         logic found;

         // k walks the slots after ptr in priority order, wrapping modulo NCH
         always_comb begin
            grant = '0;
            found = 1'b0;
            for (int k = 1; k <= NCH; k++) begin
               for (int i = 0; i < NCH; i++) begin
                  if (!found && req[i] && (i == ((int'(ptr) + k) % NCH))) begin
                     grant[i] = 1'b1;
                     found    = 1'b1;
                  end
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/sram_like_bridge.sv
// Arbitrates NCH CPU-side sram-like channels onto one sram-like master port,
// one outstanding transaction at a time. Optional SRAM_BRIDGE_MMU_MAP_EN folds kseg0/kseg1.
module sram_like_bridge
   import sram_like_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NCH      = 2,
   parameter int ARB_MODE = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NCH-1:0]        ch_req,
   input  logic [NCH-1:0]        ch_wr,
   input  logic [2*NCH-1:0]      ch_size,
   input  logic [ADDR_W*NCH-1:0] ch_addr,
   input  logic [DATA_W*NCH-1:0] ch_wdata,
   output logic [NCH-1:0]        ch_addr_ok,
   output logic [NCH-1:0]        ch_data_ok,
   output logic [DATA_W-1:0]     ch_rdata,
   output logic                  m_req,
   output logic                  m_wr,
   output logic [1:0]            m_size,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   input  logic                  m_addr_ok,
   input  logic                  m_data_ok,
   input  logic [DATA_W-1:0]     m_rdata,
   output logic                  busy
);

   localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

   bridge_state_e     state;
   bridge_state_e     state_next;
   logic [NCH-1:0]    grant;
   logic [PTR_W-1:0]  grant_idx;
   logic [PTR_W-1:0]  owner;
   logic [PTR_W-1:0]  rr_ptr;
   logic              any_req;
   logic              accept;
   logic              done;

   logic              sel_wr;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [ADDR_W-1:0] mapped_addr;

   logic              lat_wr;
   logic [1:0]        lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   rr_arbiter #(
      .NCH   (NCH),
      .MODE  (ARB_MODE),
      .PTR_W (PTR_W)
   ) u_arb (
      .req   (ch_req),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   assign any_req = |ch_req;
   assign accept  = (state == IDLE) && any_req;

   always_comb begin
      grant_idx = '0;
      sel_wr    = 1'b0;
      sel_size  = SZ_BYTE;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant[i]) begin
            grant_idx = PTR_W'(i);
            sel_wr    = ch_wr[i];
            sel_size  = ch_size[2*i +: 2];
            sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef SRAM_BRIDGE_MMU_MAP_EN
   assign mapped_addr = kseg_map(sel_addr);
`else
   assign mapped_addr = sel_addr;
`endif

   always_comb begin
      state_next = state;
      m_req      = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_req) state_next = REQ;
         end
         REQ: begin
            m_req = 1'b1;
            if (m_addr_ok) begin
               done       = m_data_ok;
               state_next = m_data_ok ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (m_data_ok) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // resetn gates the grant so a request during reset is never acknowledged
   always_comb begin
      ch_addr_ok = (accept && resetn) ? grant : '0;
      ch_data_ok = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_data_ok[i] = done && (owner == PTR_W'(i));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner     <= '0;
         rr_ptr    <= PTR_W'(NCH - 1);
         lat_wr    <= 1'b0;
         lat_size  <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         owner     <= grant_idx;
         rr_ptr    <= grant_idx;
         lat_wr    <= sel_wr;
         lat_size  <= sel_size;
         lat_addr  <= mapped_addr;
         lat_wdata <= sel_wdata;
      end
   end

   assign m_wr     = lat_wr;
   assign m_size   = lat_size;
   assign m_addr   = lat_addr;
   assign m_wdata  = lat_wdata;
   assign ch_rdata = m_rdata;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: a fixed-priority and a round-robin
// instance share stimulus and are compared every cycle against a transaction-level model.
module tb_sram_like_bridge;
   import sram_like_pkg::*;

   localparam int NCH_TB = 4;

   logic                clk = 1'b0;
   logic                resetn;
   logic [NCH_TB-1:0]   ch_req;
   logic [NCH_TB-1:0]   ch_wr;
   logic [2*NCH_TB-1:0] ch_size;
   logic [32*NCH_TB-1:0] ch_addr;
   logic [32*NCH_TB-1:0] ch_wdata;
   logic                m_addr_ok;
   logic                m_data_ok;
   logic [31:0]         m_rdata;

   logic [NCH_TB-1:0] aok_a, dok_a, aok_b, dok_b;
   logic [31:0]       rdata_a, rdata_b, maddr_a, maddr_b, mwdata_a, mwdata_b;
   logic              mreq_a, mreq_b, mwr_a, mwr_b, busy_a, busy_b;
   logic [1:0]        msize_a, msize_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          owner;
   } txn_t;

   txn_t txn_a, txn_b;
   logic mdl_busy = 1'b0;
   logic mdl_acc  = 1'b0;
   int   mdl_ptr  = NCH_TB - 1;

   always #5 clk = ~clk;

   sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .NCH(NCH_TB), .ARB_MODE(0)) dut_fix (
      .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(aok_a), .ch_data_ok(dok_a),
      .ch_rdata(rdata_a), .m_req(mreq_a), .m_wr(mwr_a), .m_size(msize_a), .m_addr(maddr_a),
      .m_wdata(mwdata_a), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .busy(busy_a)
   );

   sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .NCH(NCH_TB), .ARB_MODE(1)) dut_rr (
      .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(aok_b), .ch_data_ok(dok_b),
      .ch_rdata(rdata_b), .m_req(mreq_b), .m_wr(mwr_b), .m_size(msize_b), .m_addr(maddr_b),
      .m_wdata(mwdata_b), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .busy(busy_b)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick_fixed(input logic [NCH_TB-1:0] req);
      int g = -1;
      for (int i = 0; i < NCH_TB; i++) if (req[i]) g = i;
      return g;
   endfunction

   // Round-robin winner: requester with the smallest circular distance past ptr
   function automatic int pick_rr(input logic [NCH_TB-1:0] req, input int ptr);
      int g = -1;
      int best = NCH_TB;
      for (int i = 0; i < NCH_TB; i++) begin
         int d;
         d = (i - ptr - 1 + 2 * NCH_TB) % NCH_TB;
         if (req[i] && d < best) begin
            best = d;
            g = i;
         end
      end
      return g;
   endfunction

   function automatic logic [31:0] exp_map(input logic [31:0] a);
`ifdef SRAM_BRIDGE_MMU_MAP_EN
      return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
      return a;
`endif
   endfunction

   function automatic txn_t capture(input int g);
      txn_t t;
      t.wr    = ch_wr[g];
      t.size  = ch_size[2*g +: 2];
      t.addr  = exp_map(ch_addr[32*g +: 32]);
      t.wdata = ch_wdata[32*g +: 32];
      t.owner = g;
      return t;
   endfunction

   // Per-cycle comparison of both DUTs against the transaction model
   initial begin
      logic [NCH_TB-1:0] e_aok_a, e_aok_b, e_dok_a, e_dok_b;
      logic e_mreq, e_busy, done, start;
      int ga, gb;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            mdl_busy = 1'b0;
            mdl_acc  = 1'b0;
            mdl_ptr  = NCH_TB - 1;
            check_output("rst aok_a", 32'(aok_a), 32'd0);
            check_output("rst aok_b", 32'(aok_b), 32'd0);
            check_output("rst dok_a", 32'(dok_a), 32'd0);
            check_output("rst dok_b", 32'(dok_b), 32'd0);
            check_output("rst mreq_a", 32'(mreq_a), 32'd0);
            check_output("rst mreq_b", 32'(mreq_b), 32'd0);
            check_output("rst busy_a", 32'(busy_a), 32'd0);
            check_output("rst busy_b", 32'(busy_b), 32'd0);
         end else begin
            e_aok_a = '0; e_aok_b = '0; e_dok_a = '0; e_dok_b = '0;
            e_mreq = 1'b0; e_busy = mdl_busy; done = 1'b0; start = 1'b0;
            if (!mdl_busy) begin
               if (ch_req != '0) begin
                  ga = pick_fixed(ch_req);
                  gb = pick_rr(ch_req, mdl_ptr);
                  e_aok_a = NCH_TB'(1) << ga;
                  e_aok_b = NCH_TB'(1) << gb;
                  txn_a = capture(ga);
                  txn_b = capture(gb);
                  mdl_ptr = gb;
                  start = 1'b1;
               end
            end else begin
               e_mreq = !mdl_acc;
               done = mdl_acc ? m_data_ok : (m_addr_ok && m_data_ok);
               if (done) begin
                  e_dok_a = NCH_TB'(1) << txn_a.owner;
                  e_dok_b = NCH_TB'(1) << txn_b.owner;
               end
            end
            check_output("aok_a", 32'(aok_a), 32'(e_aok_a));
            check_output("aok_b", 32'(aok_b), 32'(e_aok_b));
            check_output("dok_a", 32'(dok_a), 32'(e_dok_a));
            check_output("dok_b", 32'(dok_b), 32'(e_dok_b));
            check_output("mreq_a", 32'(mreq_a), 32'(e_mreq));
            check_output("mreq_b", 32'(mreq_b), 32'(e_mreq));
            check_output("busy_a", 32'(busy_a), 32'(e_busy));
            check_output("busy_b", 32'(busy_b), 32'(e_busy));
            if (e_mreq) begin
               check_output("mwr_a", 32'(mwr_a), 32'(txn_a.wr));
               check_output("msize_a", 32'(msize_a), 32'(txn_a.size));
               check_output("maddr_a", maddr_a, txn_a.addr);
               check_output("mwdata_a", mwdata_a, txn_a.wdata);
               check_output("mwr_b", 32'(mwr_b), 32'(txn_b.wr));
               check_output("msize_b", 32'(msize_b), 32'(txn_b.size));
               check_output("maddr_b", maddr_b, txn_b.addr);
               check_output("mwdata_b", mwdata_b, txn_b.wdata);
            end
            if (done) begin
               check_output("rdata_a", rdata_a, m_rdata);
               check_output("rdata_b", rdata_b, m_rdata);
            end
            if (start) begin
               mdl_busy = 1'b1;
               mdl_acc  = 1'b0;
            end else if (mdl_busy) begin
               if (done) mdl_busy = 1'b0;
               else if (!mdl_acc && m_addr_ok) mdl_acc = 1'b1;
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
   endtask

   task automatic pulse_reset();
      next_cycle();
      resetn = 1'b0;
      idle_inputs();
      next_cycle();
      resetn = 1'b1;
   endtask

   task automatic apply_stimulus();
      next_cycle();
      resetn = ($urandom_range(0, 249) != 0);
      ch_req = ($urandom_range(0, 3) == 0) ? '0 : NCH_TB'($urandom_range(0, 15));
      for (int i = 0; i < NCH_TB; i++) begin
         ch_wr[i]             = 1'($urandom);
         ch_size[2*i +: 2]    = 2'($urandom_range(0, 2));
         ch_addr[32*i +: 32]  = $urandom;
         ch_wdata[32*i +: 32] = $urandom;
      end
      m_addr_ok = ($urandom_range(0, 2) != 0);
      m_data_ok = ($urandom_range(0, 2) == 0);
      m_rdata   = $urandom;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetn = 1'b1;
      idle_inputs();
      #2 resetn = 1'b0;
      next_cycle();
      next_cycle();
      resetn = 1'b1;
      @(negedge clk);
      check_output("reset busy", 32'(busy_a), 32'd0);
      check_output("reset m_req", 32'(mreq_a), 32'd0);

      // Single read, memory accepts at cycle 1 and completes at cycle 3
      next_cycle();
      ch_req = 4'b0001; ch_size[1:0] = SZ_WORD; ch_addr[31:0] = 32'h0000_1000;
      @(negedge clk);
      check_output("read c0 aok", 32'(aok_a), 32'h1);
      check_output("read c0 busy", 32'(busy_a), 32'd0);
      next_cycle();
      ch_req = '0; m_addr_ok = 1'b1;
      @(negedge clk);
      check_output("read c1 mreq", 32'(mreq_a), 32'd1);
      check_output("read c1 maddr", maddr_a, 32'h0000_1000);
      check_output("read c1 busy", 32'(busy_a), 32'd1);
      next_cycle();
      m_addr_ok = 1'b0;
      @(negedge clk);
      check_output("read c2 busy", 32'(busy_a), 32'd1);
      check_output("read c2 mreq", 32'(mreq_a), 32'd0);
      next_cycle();
      m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check_output("read c3 dok", 32'(dok_a), 32'h1);
      check_output("read c3 rdata", rdata_a, 32'hDEAD_BEEF);
      check_output("read c3 busy", 32'(busy_a), 32'd1);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check_output("read c4 busy", 32'(busy_a), 32'd0);

      // ch0/ch1 collision: fixed priority serves the data channel first
      next_cycle();
      ch_req = 4'b0011; ch_wr = 4'b0010;
      ch_addr[31:0] = 32'h0000_2000; ch_addr[63:32] = 32'h0000_3000;
      ch_wdata[63:32] = 32'h1234_5678;
      @(negedge clk);
      check_output("coll aok", 32'(aok_a), 32'h2);
      next_cycle();
      m_addr_ok = 1'b1;
      @(negedge clk);
      check_output("coll mwr", 32'(mwr_a), 32'd1);
      check_output("coll mwdata", mwdata_a, 32'h1234_5678);
      check_output("coll maddr", maddr_a, 32'h0000_3000);
      next_cycle();
      m_addr_ok = 1'b0; m_data_ok = 1'b1;
      @(negedge clk);
      check_output("coll dok ch1", 32'(dok_a), 32'h2);
      next_cycle();
      ch_req = 4'b0001; m_data_ok = 1'b0;
      @(negedge clk);
      check_output("coll aok ch0", 32'(aok_a), 32'h1);
      next_cycle();
      m_addr_ok = 1'b1; m_data_ok = 1'b1;
      @(negedge clk);
      check_output("coll dok ch0", 32'(dok_a), 32'h1);
      next_cycle();
      idle_inputs();

      // Zero-wait memory with all channels requesting: grant every 2 cycles
      pulse_reset();
      next_cycle();
      ch_req = 4'b1111; m_addr_ok = 1'b1; m_data_ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            check_output("zw rr aok", 32'(aok_b), 32'(4'b0001 << ((k / 2) % 4)));
            check_output("zw fix aok", 32'(aok_a), 32'h8);
         end else begin
            check_output("zw rr dok", 32'(dok_b), 32'(4'b0001 << ((k / 2) % 4)));
            check_output("zw fix dok", 32'(dok_a), 32'h8);
         end
      end
      next_cycle();
      idle_inputs();

      // Reset during WAIT, then a stale data_ok after release
      next_cycle();
      ch_req = 4'b0001; ch_addr[31:0] = 32'h0000_4000;
      next_cycle();
      ch_req = '0; m_addr_ok = 1'b1;
      next_cycle();
      m_addr_ok = 1'b0;
      @(negedge clk);
      check_output("mid wait busy", 32'(busy_a), 32'd1);
      next_cycle();
      resetn = 1'b0;
      @(negedge clk);
      check_output("mid rst busy", 32'(busy_a), 32'd0);
      next_cycle();
      resetn = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hCAFE_0001;
      @(negedge clk);
      check_output("stale dok", 32'(dok_a), 32'd0);
      check_output("stale busy", 32'(busy_a), 32'd0);
      next_cycle();
      idle_inputs();

      // kseg1 boot address through the optional fixed mapping
      next_cycle();
      ch_req = 4'b0001; ch_addr[31:0] = 32'hBFC0_0000;
      next_cycle();
      ch_req = '0; m_addr_ok = 1'b1; m_data_ok = 1'b1;
      @(negedge clk);
`ifdef SRAM_BRIDGE_MMU_MAP_EN
      check_output("map maddr", maddr_a, 32'h1FC0_0000);
`else
      check_output("map maddr", maddr_a, 32'hBFC0_0000);
`endif
      next_cycle();
      idle_inputs();

      for (int n = 0; n < 3000; n++) apply_stimulus();
      next_cycle();
      resetn = 1'b1;
      idle_inputs();
      repeat (4) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Parametrised successor to the direct SRAM hookup in the CPU top level.
- Arbitrates NCH CPU-side sram-like channels (default 2: ch0 = instruction fetch, ch1 = data) onto one shared sram-like master port.
- Master port uses a req/addr_ok/data_ok handshake and allows multi-cycle memory latency.
- Sits between datapath/mmu and the memory-side interface; one outstanding transaction at a time.

Parameters:
- ADDR_W, 32, address width, same on both sides.
- DATA_W, 32, data width.
- NCH, 2, number of CPU-side channels (1..8).
- ARB_MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ch_req  in  NCH  per-channel request.
- ch_wr  in  NCH  1 = write, 0 = read.
- ch_size  in  2*NCH  0 = byte, 1 = half, 2 = word; packed, ch i at [2i+1:2i].
- ch_addr  in  ADDR_W*NCH  packed addresses.
- ch_wdata  in  DATA_W*NCH  packed write data.
- ch_addr_ok  out  NCH  request accepted this cycle.
- ch_data_ok  out  NCH  transaction complete; read data valid this cycle.
- ch_rdata  out  DATA_W  read data, broadcast to all channels.
- m_req  out  1  master request.
- m_wr  out  1  master write.
- m_size  out  2  master size.
- m_addr  out  ADDR_W  master address.
- m_wdata  out  DATA_W  master write data.
- m_addr_ok  in  1  memory accepted the request.
- m_data_ok  in  1  memory completed the transaction.
- m_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset (resetn) is asynchronous and active-low.
- FSM states: IDLE, REQ, WAIT. Reset puts FSM in IDLE and owner = 0. Round-robin pointer resets to NCH-1, so ch0 has first priority.
- Outputs while resetn is low: m_req = 0, ch_addr_ok = 0, ch_data_ok = 0, busy = 0. Latched wr/size/addr/wdata registers reset to 0.
- IDLE:
  - grant = arbiter(ch_req). ch_addr_ok[g] = 1 combinationally for the granted channel only.
  - On any request: latch wr/size/addr/wdata of g and set owner = g; next state REQ.
  - Round-robin pointer advances to g on grant.
- REQ:
  - m_req = 1, driven from the latched fields, which stay stable until addr_ok.
  - m_addr_ok = 1 and m_data_ok = 0 -> WAIT.
  - m_addr_ok = 1 and m_data_ok = 1 in the same cycle -> complete this cycle, go to IDLE.
- WAIT:
  - m_req = 0.
  - m_data_ok = 1 -> ch_data_ok[owner] = 1 and ch_rdata = m_rdata in the same cycle; go to IDLE.
- Completion also applies to the REQ same-cycle case. ch_rdata is combinational passthrough of m_rdata; it is don't-care when no data_ok is asserted.
- Minimum latency: accept at cycle 0, m_req at cycle 1, data_ok at cycle 1 at the earliest (zero-wait memory).
- Throughput: one bubble cycle (IDLE) between back-to-back transactions.
- m_data_ok in IDLE is a protocol error: ignored, no ch_data_ok.
- ch_req withdrawn after addr_ok does not affect the transaction in flight.
- Fixed mode: simultaneous ch0 + ch1 requests grant ch1 (data before fetch).
- Round-robin mode: search starts at pointer+1 mod NCH and wraps.
- Reset mid-transaction: transaction is abandoned. A late m_data_ok after reset release is ignored because the FSM is in IDLE.
- Single-channel case (NCH = 1): arbiter degenerates to a pass-through of ch_req[0].

Optional Feature:
- Macro: SRAM_BRIDGE_MMU_MAP_EN.
- Defined (valid only when ADDR_W = 32): m_addr is fixed-mapped when latched.
  - kseg0/kseg1 (0x8000_0000 to 0xBFFF_FFFF) -> addr & 0x1FFF_FFFF.
  - All other addresses pass through unchanged.
- Undefined: m_addr equals the latched ch_addr bit-for-bit.

Decomposition:
- Package sram_like_pkg holds:
  - the FSM state enum (IDLE/REQ/WAIT);
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - KSEG_MASK = 0x1FFF_FFFF and the KSEG01 range constants.
- One sub-module: rr_arbiter (NCH requests, pointer in, one-hot grant out, MODE parameter for fixed vs round-robin), used in IDLE only.

Test Plan:
- Single read: ch0 read at 0x0000_1000; memory addr_ok at cycle 1, data_ok at cycle 3 with 0xDEAD_BEEF -> ch_data_ok[0] at cycle 3, ch_rdata = 0xDEAD_BEEF, busy high for cycles 1-3.
- Fixed-priority collision (ARB_MODE = 0): ch0 and ch1 request in the same cycle -> ch_addr_ok = 2'b10. ch1 write of 0x1234_5678 issues first. ch0 is granted in the first IDLE after ch1's data_ok.
- Round-robin (ARB_MODE = 1, NCH = 4): all four channels request continuously -> grant order 0, 1, 2, 3, 0.
- Zero-wait memory: m_addr_ok and m_data_ok tied to 1 -> each transaction completes in the REQ cycle. A new grant follows every 2 cycles.
- Reset mid-operation: resetn low during WAIT, then released; a stale m_data_ok arrives -> no ch_data_ok, FSM stays IDLE, busy = 0.
- Address mapping: with SRAM_BRIDGE_MMU_MAP_EN, ch_addr 0xBFC0_0000 -> m_addr 0x1FC0_0000. Without the macro, m_addr = 0xBFC0_0000.
